// File: rtl/lsh_seq.sv
// Sequential left shifter: shifts a 2**N-bit sample left one bit per clock
// with valid/ready handshakes. Define LSH_SAT_EN for signed saturation.
module lsh_seq #(
  parameter int N = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2**N-1:0] in_data,
  input  logic [N-1:0]    in_shft,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2**N-1:0] out_data,
  output logic            out_sat
);

  localparam int W = 2**N;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   data_q, data_d;
  logic [N-1:0]   cnt_q, cnt_d;
  logic           sat_q, sat_d;
`ifdef LSH_SAT_EN
  logic           ovf_q, ovf_d;
  logic           sign0_q, sign0_d;
  logic           ovf_nxt;
`endif

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    cnt_d     = cnt_q;
    sat_d     = sat_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
`ifdef LSH_SAT_EN
    ovf_d     = ovf_q;
    sign0_d   = sign0_q;
    ovf_nxt   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          data_d  = in_data;
          cnt_d   = in_shft;
          sat_d   = 1'b0;
`ifdef LSH_SAT_EN
          sign0_d = in_data[W-1];
          ovf_d   = 1'b0;
`endif
          state_d = (in_shft == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        data_d = data_q << 1;
        cnt_d  = cnt_q - N'(1);
`ifdef LSH_SAT_EN
        // Overflow whenever the bit about to become the sign differs from it.
        ovf_nxt = ovf_q | (data_q[W-1] ^ data_q[W-2]);
        ovf_d   = ovf_nxt;
`endif
        if (cnt_q == N'(1)) begin
          state_d = DONE;
`ifdef LSH_SAT_EN
          if (ovf_nxt) begin
            data_d = sign0_q ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
            sat_d  = 1'b1;
          end
`endif
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
`ifdef LSH_SAT_EN
      ovf_q   <= 1'b0;
      sign0_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
`ifdef LSH_SAT_EN
      ovf_q   <= ovf_d;
      sign0_q <= sign0_d;
`endif
    end
  end

  assign out_data = data_q;
  assign out_sat  = sat_q;

endmodule

// File: tb/tb_lsh_seq.sv
// Scoreboard testbench for lsh_seq (N=3): directed vectors, expected results
// queued at issue time and checked by an independent output monitor.
module tb_lsh_seq;

  logic       clk;
  logic       rst;
  logic       inValid;
  logic       inReady;
  logic [7:0] inData;
  logic [2:0] inShft;
  logic       outValid;
  logic       outReady;
  logic [7:0] outData;
  logic       outSat;

  int numChecks = 0;
  int numFails  = 0;
  logic [8:0] scoreboard[$];

  lsh_seq #(.N(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (inValid),
    .in_ready (inReady),
    .in_data  (inData),
    .in_shft  (inShft),
    .out_valid(outValid),
    .out_ready(outReady),
    .out_data (outData),
    .out_sat  (outSat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    numChecks++;
    if (act !== exp) begin
      numFails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every output handshake consumes one expected result.
  always @(negedge clk) begin
    if (!rst && outValid && outReady) begin
      if (scoreboard.size() == 0) begin
        checkOutput("unexpected_output", 32'(outData), 32'hFFFF_FFFF);
      end else begin
        logic [8:0] exp;
        exp = scoreboard.pop_front();
        checkOutput("out_data", 32'(outData), 32'(exp[8:1]));
        checkOutput("out_sat", 32'(outSat), 32'(exp[0]));
      end
    end
  end

  // Issue one transaction and check in_ready/latency up to out_valid rising.
  task automatic applyStimulus(input logic [7:0] d, input logic [2:0] s,
                               input logic [7:0] expData, input logic expSat);
    int cyc;
    cyc = 0;
    while (!inReady && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    checkOutput("in_ready_before_accept", 32'(inReady), 32'd1);
    inValid = 1'b1;
    inData  = d;
    inShft  = s;
    scoreboard.push_back({expData, expSat});
    @(posedge clk); #1;
    inValid = 1'b0;
    cyc = 0;
    while (!outValid && cyc < 20) begin
      checkOutput("in_ready_busy", 32'(inReady), 32'd0);
      @(posedge clk); #1;
      cyc++;
    end
    checkOutput("latency", 32'(cyc), 32'(s));
    checkOutput("in_ready_done", 32'(inReady), 32'd0);
  endtask

  task automatic waitHandshake();
    int cyc;
    cyc = 0;
    while (outValid && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    checkOutput("out_valid_after_hs", 32'(outValid), 32'd0);
    checkOutput("in_ready_after_hs", 32'(inReady), 32'd1);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst      = 1'b1;
    inValid  = 1'b0;
    inData   = 8'h00;
    inShft   = 3'd0;
    outReady = 1'b1;
    #12;
    checkOutput("reset_in_ready", 32'(inReady), 32'd1);
    checkOutput("reset_out_valid", 32'(outValid), 32'd0);
    checkOutput("reset_out_data", 32'(outData), 32'd0);
    checkOutput("reset_out_sat", 32'(outSat), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    applyStimulus(8'h16, 3'd2, 8'h58, 1'b0);
    waitHandshake();
    applyStimulus(8'hA5, 3'd0, 8'hA5, 1'b0);
    waitHandshake();
`ifdef LSH_SAT_EN
    applyStimulus(8'h30, 3'd2, 8'h7F, 1'b1);
    waitHandshake();
    applyStimulus(8'hF0, 3'd3, 8'h80, 1'b0);
    waitHandshake();
    applyStimulus(8'hF0, 3'd4, 8'h80, 1'b1);
    waitHandshake();
    applyStimulus(8'h81, 3'd1, 8'h80, 1'b1);
    waitHandshake();
`else
    applyStimulus(8'h30, 3'd2, 8'hC0, 1'b0);
    waitHandshake();
    applyStimulus(8'hF0, 3'd3, 8'h80, 1'b0);
    waitHandshake();
    applyStimulus(8'hF0, 3'd4, 8'h00, 1'b0);
    waitHandshake();
    applyStimulus(8'h81, 3'd1, 8'h02, 1'b0);
    waitHandshake();
`endif

    // Backpressure: result must hold and stray inputs must be ignored.
    outReady = 1'b0;
`ifdef LSH_SAT_EN
    applyStimulus(8'h01, 3'd7, 8'h7F, 1'b1);
`else
    applyStimulus(8'h01, 3'd7, 8'h80, 1'b0);
`endif
    for (int i = 0; i < 5; i++) begin
      inValid = (i % 2 == 0);
      inData  = 8'hFF;
      inShft  = 3'd0;
      @(posedge clk); #1;
      checkOutput("bp_out_valid", 32'(outValid), 32'd1);
`ifdef LSH_SAT_EN
      checkOutput("bp_out_data", 32'(outData), 32'h7F);
`else
      checkOutput("bp_out_data", 32'(outData), 32'h80);
`endif
      checkOutput("bp_in_ready", 32'(inReady), 32'd0);
    end
    inValid  = 1'b0;
    outReady = 1'b1;
    @(posedge clk); #1;
    checkOutput("bp_release_valid", 32'(outValid), 32'd0);
    checkOutput("bp_release_ready", 32'(inReady), 32'd1);
    @(posedge clk); #1;
    checkOutput("bp_single_transfer", 32'(outValid), 32'd0);

    // Reset on the 2nd SHIFT cycle aborts the transaction.
    inValid = 1'b1;
    inData  = 8'h55;
    inShft  = 3'd5;
    @(posedge clk); #1;
    inValid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checkOutput("midrst_in_ready", 32'(inReady), 32'd1);
    checkOutput("midrst_out_valid", 32'(outValid), 32'd0);
    checkOutput("midrst_out_data", 32'(outData), 32'd0);
    checkOutput("midrst_out_sat", 32'(outSat), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    applyStimulus(8'h03, 3'd1, 8'h06, 1'b0);
    waitHandshake();

    repeat (3) @(posedge clk);
    #1;
    checkOutput("scoreboard_empty", 32'(scoreboard.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", numChecks, numFails);
    $finish;
  end

endmodule

// File: doc/lsh_seq.md
# lsh_seq

Sequential left shifter for the FFT datapath. It takes one `2**N`-bit sample per transaction and left-shifts it by a runtime amount, one bit per clock, with valid/ready handshakes on both sides. It sits at the FFT output and undoes the per-stage right-shift scaling applied by `rsh_n` inside the butterflies. Optional signed saturation is available.

## Interface
Parameters:
- `N`, default 3: data width is `W = 2**N` bits (8 by default). Shift amount is `N` bits wide, so the maximum shift is `2**N - 1`.

Ports:
- `clk`  input  1  sole clock; all state updates on the rising edge.
- `rst`  input  1  reset, asynchronous, active-high.
- `in_valid`  input  1  `in_data`/`in_shft` valid.
- `in_ready`  output  1  block can accept a transaction.
- `in_data`  input  W  sample to shift.
- `in_shft`  input  N  left-shift amount, 0 to `2**N - 1`.
- `out_valid`  output  1  `out_data`/`out_sat` valid.
- `out_ready`  input  1  downstream accepts the result.
- `out_data`  output  W  shifted result.
- `out_sat`  output  1  result was saturated; always 0 when saturation is compiled out.

## Operation
- **FSM states:** IDLE, SHIFT, DONE. Reset state is IDLE.
- **IDLE:**
  - `in_ready = 1`.
  - On `in_valid && in_ready`: capture `in_data` into the data register, `in_shft` into the counter `cnt`, and `in_data[W-1]` into `sign0`; clear the sticky `ovf` flag.
  - If `in_shft == 0`, go to DONE; otherwise go to SHIFT.
- **SHIFT:**
  - Each cycle: data <= data << 1 (zero fill at the LSB), `cnt <= cnt - 1`.
  - If `cnt == 1`, go to DONE.
  - `in_ready = 0`.
- **DONE:**
  - `out_valid = 1`. `out_data` and `out_sat` are held stable.
  - On `out_valid && out_ready`: go to IDLE.
  - `in_ready = 0`; no new input is accepted in the same cycle as the output handshake.
- **Arithmetic:** `W`-bit logical left shift; bits shifted out of the MSB are discarded, unless saturation applies (see Configuration).
- **Boundary cases:**
  - `in_shft = 0`: passthrough, `out_data = in_data`.
  - `in_shft = 2**N - 1`: only the LSB survives, moved to the MSB.
  - `out_ready` held low: DONE persists indefinitely and outputs do not change.
  - `in_valid` while busy: ignored (not captured); the upstream must hold it.
- **Reset mid-operation:** the transaction is aborted immediately and not replayed.
- **Reset values:**
  - state = IDLE, `in_ready = 1`, `out_valid = 0`, `out_data = 0`, `out_sat = 0`.
  - Internal: `cnt = 0`, `ovf = 0`, `sign0 = 0`.

## Timing
- All outputs are registered or decoded from registered state; there are no combinational in-to-out paths.
- **Latency:** input accepted on edge E gives `out_valid` high after edge `E + in_shft`. A shift of 0 means `out_valid` is high in the cycle right after the accept edge.
- **Throughput:** one transaction per `in_shft + 2` cycles when `out_ready = 1`:
  - accept edge,
  - `in_shft` shift edges,
  - output handshake edge,
  - IDLE cycle before the next accept.
- `out_valid` falls on the edge where `out_valid && out_ready`.
- `in_ready` rises on that same edge.

## Configuration
- Macro `LSH_SAT_EN`.
- **Defined:**
  - Data is treated as signed two's complement.
  - Each SHIFT cycle sets sticky `ovf` if `data[W-1] != data[W-2]` before the shift.
  - On entering DONE with `ovf = 1`: `out_data = sign0 ? {1'b1, {W-1{1'b0}}} : {1'b0, {W-1{1'b1}}}`, and `out_sat = 1`.
  - Otherwise `out_data` is the plain shifted value and `out_sat = 0`.
- **Not defined:**
  - Pure logical shift.
  - `ovf`/`sign0` logic is absent and `out_sat` is tied to 0.

## Test plan
All cases use N=3 (W=8).
- **Basic shift:** reset, then `in_data=8'h16`, `in_shft=2`, `out_ready=1` -> `out_data=8'h58`, `out_sat=0`, `out_valid` high 2 edges after accept. `in_ready` stays low until the output handshake.
- **Passthrough:** `in_data=8'hA5`, `in_shft=0` -> `out_data=8'hA5`, `out_valid` high in the cycle after accept.
- **Positive overflow:** `in_data=8'h30`, `in_shft=2`:
  - With `LSH_SAT_EN`: `out_data=8'h7F`, `out_sat=1`.
  - Without: `out_data=8'hC0`, `out_sat=0`.
- **Negative cases** (`LSH_SAT_EN` defined):
  - `in_data=8'hF0`, `in_shft=3` -> `8'h80`, `out_sat=0`.
  - `in_data=8'hF0`, `in_shft=4` -> `8'h80`, `out_sat=1`.
- **Backpressure:** `in_data=8'h01`, `in_shft=7`, `out_ready=0` for 5 cycles after `out_valid` rises:
  - `out_data=8'h80` is held stable throughout.
  - `in_valid` pulses during that window are ignored.
  - Raising `out_ready` completes exactly one transfer.
- **Reset mid-shift:** `in_shft=5`, assert `rst` on the 2nd SHIFT cycle -> all outputs immediately at their reset values, `in_ready=1`. A following transaction `8'h03`, `in_shft=1` -> `8'h06`.
